// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter in front of a shared registered ALU
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (port 0 always wins ties; default is round-robin)
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [31:0] resp_result,
    output logic        resp_zero,
    output logic        resp_err
);

    localparam int LAST = ALU_LAT - 1;

    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        op_err;
    logic [2:0]  sel_op;

    logic [ALU_LAT-1:0] pipe_valid;
    logic [ALU_LAT-1:0] pipe_id;
    logic [ALU_LAT-1:0] pipe_err;

    function automatic logic op_supported(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_supported = 1'b1;
            default:                                op_supported = 1'b0;
        endcase
    endfunction

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: port 0 wins whenever it is valid; nothing is granted during reset
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            grant0 = req0_valid;
            grant1 = req1_valid && !req0_valid;
        end
    end
`else
    logic last_grant;

    // Round-robin: on a tie the port that did not win last time is granted
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    // Remember the most recently accepted port; resets to 1 so port 0 wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant1;
        end
    end
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;

    // Steer the granted port's operands to the ALU; unsupported ops run as AND and are flagged
    always_comb begin
        alu_a  = 32'd0;
        alu_b  = 32'd0;
        sel_op = 3'b000;
        if (grant0) begin
            alu_a  = req0_a;
            alu_b  = req0_b;
            sel_op = req0_op;
        end else if (grant1) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            sel_op = req1_op;
        end
        op_err   = accept && !op_supported(sel_op);
        alu_ctrl = op_err ? 3'b000 : sel_op;
    end

    // In-flight tracker: one {valid, id, err} stage per ALU latency cycle, shifting every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
            pipe_id    <= '0;
            pipe_err   <= '0;
        end else begin
            pipe_valid[0] <= accept;
            pipe_id[0]    <= grant1;
            pipe_err[0]   <= op_err;
            for (int i = 1; i < ALU_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_id[i]    <= pipe_id[i-1];
                pipe_err[i]   <= pipe_err[i-1];
            end
        end
    end

    // Response register: capture the ALU result when the tracked request reaches the last stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= 32'd0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            resp_valid <= pipe_valid[LAST];
            if (pipe_valid[LAST]) begin
                resp_id  <= pipe_id[LAST];
                resp_err <= pipe_err[LAST];
                if (pipe_err[LAST]) begin
                    resp_result <= 32'd0;
                    resp_zero   <= 1'b1;
                end else begin
                    resp_result <= alu_result;
                    resp_zero   <= (alu_result == 32'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    localparam int ALU_LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_ctrl;
    logic        resp_valid, resp_id, resp_zero, resp_err;
    logic [31:0] resp_result;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] alu_q [ALU_LAT];

    alu_arbiter #(.ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
        .resp_zero(resp_zero), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] ctrl);
        case (ctrl)
            3'b000:  alu_f = a & b;
            3'b001:  alu_f = a | b;
            3'b010:  alu_f = a + b;
            3'b110:  alu_f = a - b;
            3'b111:  alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: alu_f = 32'd0;
        endcase
    endfunction

    // Registered ALU stand-in with a fixed latency of ALU_LAT cycles
    always_ff @(posedge clk) begin
        alu_q[0] <= alu_f(alu_a, alu_b, alu_ctrl);
        for (int i = 1; i < ALU_LAT; i++) alu_q[i] <= alu_q[i-1];
    end
    assign alu_result = alu_q[ALU_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    endtask

    task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    endtask

    task automatic drive1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    endtask

    // Called in the issue cycle after the grant checks; walks to the response cycle
    task automatic wait_resp(input string tag, input logic exp_id, input logic [31:0] exp_res,
                             input logic exp_zero, input logic exp_err);
        for (int k = 1; k <= ALU_LAT; k++) begin
            next_cycle();
            if (k == 1) idle();
            chk({tag, "_early"}, resp_valid, 1'b0);
        end
        next_cycle();
        chk({tag, "_valid"}, resp_valid, 1'b1);
        chk({tag, "_id"}, resp_id, exp_id);
        chk({tag, "_result"}, resp_result, exp_res);
        chk({tag, "_zero"}, resp_zero, exp_zero);
        chk({tag, "_err"}, resp_err, exp_err);
        next_cycle();
        chk({tag, "_oneshot"}, resp_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        next_cycle();
        next_cycle();

        // Reset state, with both ports requesting
        drive0(32'd5, 32'd7, 3'b010);
        drive1(32'd9, 32'd9, 3'b110);
        #1;
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_ctrl", alu_ctrl, 3'd0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_id", resp_id, 1'b0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_resp_zero", resp_zero, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        idle();
        next_cycle();
        reset = 1'b0;

        // Port 0 ADD 5+7
        next_cycle();
        drive0(32'd5, 32'd7, 3'b010);
        #1;
        chk("add_ready0", req0_ready, 1'b1);
        chk("add_ready1", req1_ready, 1'b0);
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        chk("add_alu_ctrl", alu_ctrl, 3'b010);
        wait_resp("add", 1'b0, 32'd12, 1'b0, 1'b0);

        // Port 1 SUB 9-9 -> zero result
        drive1(32'd9, 32'd9, 3'b110);
        #1;
        chk("sub_ready0", req0_ready, 1'b0);
        chk("sub_ready1", req1_ready, 1'b1);
        chk("sub_alu_a", alu_a, 32'd9);
        chk("sub_alu_ctrl", alu_ctrl, 3'b110);
        wait_resp("sub", 1'b1, 32'd0, 1'b1, 1'b0);

        // Port 1 SLT -1 < 1 (signed)
        drive1(32'hFFFF_FFFF, 32'd1, 3'b111);
        #1;
        chk("slt_ready1", req1_ready, 1'b1);
        chk("slt_alu_ctrl", alu_ctrl, 3'b111);
        wait_resp("slt", 1'b1, 32'd1, 1'b0, 1'b0);

        // Unsupported op 011 on port 0: ALU sees AND, response forced to zero with err
        drive0(32'd1, 32'd1, 3'b011);
        #1;
        chk("bad_ready0", req0_ready, 1'b1);
        chk("bad_alu_ctrl", alu_ctrl, 3'b000);
        chk("bad_alu_a", alu_a, 32'd1);
        wait_resp("bad", 1'b0, 32'd0, 1'b1, 1'b1);

        // Both ports valid for 6 cycles straight out of reset
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 6 + ALU_LAT + 2; i++) begin
            if (i < 6) begin
                drive0(32'd100, 32'd1, 3'b010);
                drive1(32'h0000_00F0, 32'h0000_000F, 3'b001);
            end else begin
                idle();
            end
            #1;
            if (i < 6) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                chk($sformatf("tie%0d_ready0", i), req0_ready, 1'b1);
                chk($sformatf("tie%0d_ready1", i), req1_ready, 1'b0);
`else
                chk($sformatf("tie%0d_ready0", i), req0_ready, (i % 2) == 0);
                chk($sformatf("tie%0d_ready1", i), req1_ready, (i % 2) == 1);
`endif
            end
            if (i < ALU_LAT + 1) begin
                chk($sformatf("tie%0d_resp_idle", i), resp_valid, 1'b0);
            end else if (i < 6 + ALU_LAT + 1) begin
                chk($sformatf("tie%0d_resp_valid", i), resp_valid, 1'b1);
`ifdef ALU_ARB_FIXED_PRIO_EN
                chk($sformatf("tie%0d_resp_id", i), resp_id, 1'b0);
                chk($sformatf("tie%0d_resp_result", i), resp_result, 32'd101);
`else
                chk($sformatf("tie%0d_resp_id", i), resp_id, ((i - ALU_LAT - 1) % 2) == 1);
                chk($sformatf("tie%0d_resp_result", i), resp_result,
                    ((i - ALU_LAT - 1) % 2) == 1 ? 32'd255 : 32'd101);
`endif
            end else begin
                chk($sformatf("tie%0d_resp_done", i), resp_valid, 1'b0);
            end
            next_cycle();
        end

        // Reset mid-flight: accepted request is dropped, no response ever appears
        drive0(32'd2, 32'd3, 3'b010);
        #1;
        chk("mid_ready0", req0_ready, 1'b1);
        next_cycle();
        idle();
        drive1(32'd6, 32'd3, 3'b000);
        #1;
        chk("mid_ready1", req1_ready, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_resp_a", resp_valid, 1'b0);
        chk("mid_ready1_rst", req1_ready, 1'b0);
        idle();
        for (int k = 0; k < ALU_LAT + 2; k++) begin
            next_cycle();
            chk($sformatf("mid_resp_%0d", k), resp_valid, 1'b0);
        end
        reset = 1'b0;
        drive0(32'd4, 32'd4, 3'b000);
        drive1(32'd8, 32'd8, 3'b000);
        #1;
        chk("post_rst_ready0", req0_ready, 1'b1);
        chk("post_rst_ready1", req1_ready, 1'b0);
        chk("post_rst_alu_a", alu_a, 32'd4);
        wait_resp("post_rst", 1'b0, 32'd4, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
